m6502_step_ctrl: RTL and testbench

Single-step and run/halt controller for the 6502 debug board. It consumes the debounced step-button level produced by the board's NAND RS latch and the run/step mode switches. It drives the 6502 RDY line so the CPU can free-run, halt at an opcode fetch, or advance one instruction or one bus cycle per button press. It also keeps a step counter and a watchdog fault flag for the status LEDs.

---
 rtl/m6502_step_ctrl_if.sv | 13 +
 rtl/m6502_step_ctrl.sv | 60 ++++++
 tb/tb_m6502_step_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/m6502_step_ctrl_if.sv
// m6502_step_ctrl_if: debug-board bus (in: step_q, run_mode, cycle_mode, cpu_sync; out: rdy, halted, fault, step_count)
interface m6502_step_ctrl_if;
  logic step_q;
  logic run_mode;
  logic cycle_mode;
  logic cpu_sync;
  logic rdy;
  logic halted;
  logic fault;
  logic [15:0] step_count;
  modport master(output step_q, run_mode, cycle_mode, cpu_sync, input rdy, halted, fault, step_count);
  modport slave(input step_q, run_mode, cycle_mode, cpu_sync, output rdy, halted, fault, step_count);
endinterface

// File: rtl/m6502_step_ctrl.sv
// m6502_step_ctrl: 6502 RDY run/halt/single-step controller (clk, rst async high; bus: step_q/run_mode/cycle_mode/cpu_sync in, rdy/halted/fault/step_count out)
module m6502_step_ctrl #(
  parameter int MAX_CYCLES = 8
) (
  input logic clk,
  input logic rst,
  m6502_step_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, HALT, STEP_CYC, STEP_INS} state_t;
  state_t state, state_nx;
  logic step_m, step_s, step_d, run_m, run_s, cyc_m, cyc_s;
  logic seen_ns;
  logic [3:0] wd_cnt;
  logic step_pulse, ins_done, wd_hit, cnt_inc;
  assign step_pulse = step_s & ~step_d;
  assign ins_done = seen_ns & bus.cpu_sync;
  assign wd_hit = wd_cnt == 4'(MAX_CYCLES - 1);
  assign cnt_inc = (state == STEP_CYC) | (state == STEP_INS & state_nx == HALT & ins_done);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= HALT;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      RUN:      state_nx = (~run_s & bus.cpu_sync) ? HALT : RUN;
      HALT:     state_nx = run_s ? RUN : step_pulse ? (cyc_s ? STEP_CYC : STEP_INS) : HALT;
      STEP_CYC: state_nx = HALT;
      STEP_INS: state_nx = run_s ? RUN : (ins_done | wd_hit) ? HALT : STEP_INS;
    endcase
  end
  always_comb
    bus.rdy = state == RUN      ? ~(~run_s & bus.cpu_sync) :
              state == STEP_CYC ? 1'b1 :
              state == STEP_INS ? ~ins_done : 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {step_m, step_s, step_d, run_m, run_s, cyc_m, cyc_s} <= '0;
      seen_ns <= 1'b0;
      wd_cnt <= '0;
      bus.halted <= 1'b1;
      bus.fault <= 1'b0;
      bus.step_count <= '0;
    end else begin
      {step_d, step_s, step_m} <= {step_s, step_m, bus.step_q};
      {run_s, run_m} <= {run_m, bus.run_mode};
      {cyc_s, cyc_m} <= {cyc_m, bus.cycle_mode};
      bus.halted <= state_nx == HALT;
      if (state == HALT && state_nx == STEP_INS) begin
        seen_ns <= 1'b0;
        wd_cnt <= '0;
        bus.fault <= 1'b0;
      end else if (state == STEP_INS) begin
        if (!bus.cpu_sync) seen_ns <= 1'b1;
        wd_cnt <= wd_cnt + 4'd1;
        // returning to HALT without a completed fetch can only be the watchdog
        if (state_nx == HALT && !ins_done) bus.fault <= 1'b1;
      end
      if (cnt_inc) bus.step_count <= bus.step_count + 16'd1;
    end
endmodule

// File: tb/tb_m6502_step_ctrl.sv
// tb_m6502_step_ctrl: directed self-checking bench for m6502_step_ctrl
module tb_m6502_step_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  m6502_step_ctrl_if bus();
  m6502_step_ctrl #(.MAX_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic cyc(input logic s);
    @(posedge clk);
    #1 bus.cpu_sync = s;
    #1;
  endtask
  task automatic test_reset;
    cyc(1'b0);
    cyc(1'b0);
    tests++; if (bus.rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %b want 0", bus.rdy); end
    tests++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL reset_halted: got %b want 1", bus.halted); end
    tests++; if (bus.fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
    tests++; if (bus.step_count !== 16'h0000) begin fails++; $display("FAIL reset_count: got %h want 0000", bus.step_count); end
    rst = 1'b0;
    cyc(1'b0);
    bus.run_mode = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    tests++; if (bus.rdy !== 1'b0) begin fails++; $display("FAIL run_latency_early: got %b want 0", bus.rdy); end
    cyc(1'b0);
    tests++; if (bus.rdy !== 1'b1) begin fails++; $display("FAIL run_latency_rdy: got %b want 1", bus.rdy); end
    tests++; if (bus.halted !== 1'b0) begin fails++; $display("FAIL run_halted: got %b want 0", bus.halted); end
  endtask
  task automatic test_run_halt;
    bus.run_mode = 1'b0;
    cyc(1'b1);
    tests++; if (bus.rdy !== 1'b1) begin fails++; $display("FAIL halt_sync_before_sync: got %b want 1", bus.rdy); end
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    tests++; if (bus.rdy !== 1'b1) begin fails++; $display("FAIL halt_nosync_rdy: got %b want 1", bus.rdy); end
    cyc(1'b1);
    tests++; if (bus.rdy !== 1'b0) begin fails++; $display("FAIL halt_sync_rdy: got %b want 0", bus.rdy); end
    tests++; if (bus.halted !== 1'b0) begin fails++; $display("FAIL halt_not_yet: got %b want 0", bus.halted); end
    cyc(1'b0);
    tests++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL halt_halted: got %b want 1", bus.halted); end
    tests++; if (bus.rdy !== 1'b0) begin fails++; $display("FAIL halt_rdy_held: got %b want 0", bus.rdy); end
  endtask
  task automatic test_ins_step;
    logic [6:0] sy, er;
    sy = 7'b1100111;
    er = 7'b0011100;
    bus.step_q = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc(sy[i]);
      if (i == 1) bus.step_q = 1'b0;
      tests++; if (bus.rdy !== er[i]) begin fails++; $display("FAIL ins_rdy[%0d]: got %b want %b", i, bus.rdy, er[i]); end
    end
    tests++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL ins_halted: got %b want 1", bus.halted); end
    tests++; if (bus.step_count !== 16'd1) begin fails++; $display("FAIL ins_count: got %0d want 1", bus.step_count); end
    tests++; if (bus.fault !== 1'b0) begin fails++; $display("FAIL ins_fault: got %b want 0", bus.fault); end
  endtask
  task automatic test_cycle_step;
    logic exp;
    bus.cycle_mode = 1'b1;
    repeat (3) cyc(1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) bus.step_q = 1'b1;
      cyc(1'b1);
      if (i % 4 == 1) bus.step_q = 1'b0;
      exp = (i % 4 == 2);
      tests++; if (bus.rdy !== exp) begin fails++; $display("FAIL cyc_rdy[%0d]: got %b want %b", i, bus.rdy, exp); end
    end
    tests++; if (bus.step_count !== 16'd4) begin fails++; $display("FAIL cyc_count: got %0d want 4", bus.step_count); end
    tests++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL cyc_halted: got %b want 1", bus.halted); end
  endtask
  task automatic test_watchdog;
    logic exp;
    bus.cycle_mode = 1'b0;
    repeat (3) cyc(1'b0);
    bus.step_q = 1'b1;
    for (int i = 0; i < 11; i++) begin
      cyc(1'b0);
      if (i == 1) bus.step_q = 1'b0;
      exp = (i >= 2 && i <= 9);
      tests++; if (bus.rdy !== exp) begin fails++; $display("FAIL wd_rdy[%0d]: got %b want %b", i, bus.rdy, exp); end
      if (i == 9) begin
        tests++; if (bus.fault !== 1'b0) begin fails++; $display("FAIL wd_fault_early: got %b want 0", bus.fault); end
      end
    end
    tests++; if (bus.fault !== 1'b1) begin fails++; $display("FAIL wd_fault: got %b want 1", bus.fault); end
    tests++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL wd_halted: got %b want 1", bus.halted); end
    tests++; if (bus.step_count !== 16'd4) begin fails++; $display("FAIL wd_count: got %0d want 4", bus.step_count); end
    bus.step_q = 1'b1;
    cyc(1'b0);
    tests++; if (bus.fault !== 1'b1) begin fails++; $display("FAIL wd_fault_sticky: got %b want 1", bus.fault); end
    cyc(1'b0);
    bus.step_q = 1'b0;
    cyc(1'b0);
    tests++; if (bus.fault !== 1'b0) begin fails++; $display("FAIL wd_fault_clear: got %b want 0", bus.fault); end
    tests++; if (bus.rdy !== 1'b1) begin fails++; $display("FAIL wd_restep_rdy: got %b want 1", bus.rdy); end
    cyc(1'b1);
    tests++; if (bus.rdy !== 1'b0) begin fails++; $display("FAIL wd_restep_done: got %b want 0", bus.rdy); end
    cyc(1'b0);
    tests++; if (bus.step_count !== 16'd5) begin fails++; $display("FAIL wd_restep_count: got %0d want 5", bus.step_count); end
  endtask
  task automatic test_wrap_and_reset;
    bus.cycle_mode = 1'b1;
    repeat (3) cyc(1'b0);
    force bus.step_count = 16'hFFFF;
    #1 release bus.step_count;
    bus.step_q = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    bus.step_q = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    tests++; if (bus.step_count !== 16'h0000) begin fails++; $display("FAIL wrap_count: got %h want 0000", bus.step_count); end
    bus.cycle_mode = 1'b0;
    repeat (3) cyc(1'b0);
    bus.step_q = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    bus.step_q = 1'b0;
    cyc(1'b0);
    tests++; if (bus.rdy !== 1'b1) begin fails++; $display("FAIL rst_step_rdy: got %b want 1", bus.rdy); end
    cyc(1'b0);
    rst = 1'b1;
    #1;
    tests++; if (bus.rdy !== 1'b0) begin fails++; $display("FAIL rst_mid_rdy: got %b want 0", bus.rdy); end
    tests++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL rst_mid_halted: got %b want 1", bus.halted); end
    tests++; if (bus.fault !== 1'b0) begin fails++; $display("FAIL rst_mid_fault: got %b want 0", bus.fault); end
    tests++; if (bus.step_count !== 16'h0000) begin fails++; $display("FAIL rst_mid_count: got %h want 0000", bus.step_count); end
    rst = 1'b0;
    cyc(1'b1);
    tests++; if (bus.rdy !== 1'b0) begin fails++; $display("FAIL rst_after_rdy: got %b want 0", bus.rdy); end
    tests++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL rst_after_halted: got %b want 1", bus.halted); end
  endtask
  initial begin
    bus.step_q = 1'b0;
    bus.run_mode = 1'b0;
    bus.cycle_mode = 1'b0;
    bus.cpu_sync = 1'b0;
    test_reset;
    test_run_halt;
    test_ins_step;
    test_cycle_step;
    test_watchdog;
    test_wrap_and_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
